muldiv_sequencer: RTL and testbench

- Iterative multiply/divide unit that sits beside the single-cycle ALU in the EX stage and owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU, runs a 32-iteration shift-add or restoring-subtract loop, then sign-corrects and commits HI/LO.
- Services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.
- Raises stall to the hazard unit while the pipeline needs a result that is still being computed.

---
 rtl/muldiv_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Runs WIDTH shift-add (multiply) or restoring-subtract (divide) steps on
// absolute values, then applies sign correction and commits HI/LO.
//
// state  | meaning
// IDLE   | waiting for start; services MTHI/MTLO writes
// CALC   | one multiply/divide iteration per clock, WIDTH iterations
// FIX    | sign correction, HI/LO commit, done pulse next cycle
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;      // multiply: {partial sum, multiplier}; divide: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_opb;      // multiplicand or divisor magnitude
  logic               r_is_div;
  logic               r_neg_q;    // negate product/quotient at FIX
  logic               r_neg_r;    // negate remainder at FIX
  logic               r_div0;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic [WIDTH-1:0]   w_rs_abs;
  logic [WIDTH-1:0]   w_rt_abs;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_sh;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Operand magnitudes for the start edge; op[0] selects signed handling.
  always_comb begin
    w_signed = op[0];
    w_rs_abs = (w_signed && rs_val[WIDTH-1]) ? (~rs_val + 1'b1) : rs_val;
    w_rt_abs = (w_signed && rt_val[WIDTH-1]) ? (~rt_val + 1'b1) : rt_val;
  end

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_ge   = (w_div_sh >= {1'b0, r_opb});
    // Difference is always below the divisor, so the low WIDTH bits are exact.
    w_div_diff = w_div_sh[WIDTH-1:0] - r_opb;
    if (w_div_ge) begin
      w_div_next = {w_div_diff, r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_div_next = {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and HI/LO selection for the FIX commit.
  // On divide-by-zero the restoring loop leaves |rs| in the remainder and all
  // ones in the quotient; re-applying the dividend sign restores rs exactly,
  // while the quotient is forced to all ones without sign fix.
  always_comb begin
    w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_quo_fix  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    w_rem_fix  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
    if (r_is_div) begin
      w_fix_hi = w_rem_fix;
      w_fix_lo = r_div0 ? '1 : w_quo_fix;
    end else begin
      w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod_fix[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    stall = busy & (rd_req | start);
  end

  // Datapath: operand capture, iteration, commit, and MTHI/MTLO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_acc    <= {{WIDTH{1'b0}}, w_rs_abs};
            r_opb    <= w_rt_abs;
            r_neg_q  <= w_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            r_neg_r  <= w_signed & rs_val[WIDTH-1];
            r_div0   <= (rt_val == '0);
            r_cnt    <= '0;
          end else begin
            if (mthi) begin
              r_hi <= wdata;
            end
            if (mtlo) begin
              r_lo <= wdata;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: result values, timing, stall, reset abort.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         rd_req;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks;
  int failures;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .rd_req (rd_req),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; operands are scrambled afterwards to show they
  // are consumed only at the start edge. Returns at the negedge after that edge.
  task automatic issue(input logic [1:0] i_op, input logic [W-1:0] i_rs, input logic [W-1:0] i_rt);
    @(negedge clk);
    start  = 1'b1;
    op     = i_op;
    rs_val = i_rs;
    rt_val = i_rt;
    @(negedge clk);
    start  = 1'b0;
    rs_val = 32'hA5A5_5A5A;
    rt_val = 32'h1357_9BDF;
  endtask

  // Counts busy cycles until done is seen (bounded); stops on the done cycle.
  task automatic wait_done(output int o_busy, output bit o_got);
    o_busy = 0;
    o_got  = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done) begin
        o_got = 1'b1;
        break;
      end
      if (busy) o_busy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
  endtask

  task automatic test_mult();
    int nb;
    bit got;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(nb, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL mult_done_timeout: got %b expected 1", got); end
    checks++; if (nb !== 33) begin failures++; $display("FAIL mult_busy_cycles: got %0d expected 33", nb); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy_at_done: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_width: got %b expected 0", done); end
  endtask

  task automatic test_multu_signed_pair();
    int nb;
    bit got;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(nb, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL multu_done_timeout: got %b expected 1", got); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(nb, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL multm1_done_timeout: got %b expected 1", got); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL multm1_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h1) begin failures++; $display("FAIL multm1_lo: got %h expected 00000001", lo); end
  endtask

  task automatic test_div();
    int nb;
    bit got;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(nb, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL div_done_timeout: got %b expected 1", got); end
    checks++; if (nb !== 33) begin failures++; $display("FAIL div_busy_cycles: got %0d expected 33", nb); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(nb, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL divu_done_timeout: got %b expected 1", got); end
    checks++; if (lo !== 32'd14) begin failures++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin failures++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
  endtask

  task automatic test_div_corners();
    int nb;
    bit got;
    issue(OP_DIVU, 32'd100, 32'd0);
    wait_done(nb, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL divu0_done_timeout: got %b expected 1", got); end
    checks++; if (nb !== 33) begin failures++; $display("FAIL divu0_busy_cycles: got %0d expected 33", nb); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu0_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'h0000_0064) begin failures++; $display("FAIL divu0_hi: got %h expected 00000064", hi); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(nb, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL div0s_done_timeout: got %b expected 1", got); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0s_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'hFFFF_FFF9) begin failures++; $display("FAIL div0s_hi: got %h expected fffffff9", hi); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(nb, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL divovf_done_timeout: got %b expected 1", got); end
    checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL divovf_lo: got %h expected 80000000", lo); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL divovf_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_stall_and_ignored();
    bit got;
    int done_c;
    got    = 1'b0;
    done_c = -1;
    issue(OP_MULT, 32'd6, 32'd7);
    for (int c = 0; c < 60; c++) begin
      rd_req = (c >= 5);
      start  = (c == 10);
      mtlo   = (c == 10);
      mthi   = (c == 12);
      op     = OP_DIVU;
      rs_val = 32'd1;
      rt_val = 32'd1;
      wdata  = 32'hDEAD_BEEF;
      #1;
      if (done) begin
        got    = 1'b1;
        done_c = c;
        break;
      end
      checks++; if (stall !== ((c >= 5) || (c == 10))) begin
        failures++; $display("FAIL stall_c%0d: got %b expected %b", c, stall, ((c >= 5) || (c == 10)));
      end
      @(negedge clk);
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL stall_done_timeout: got %b expected 1", got); end
    checks++; if (done_c !== 33) begin failures++; $display("FAIL stall_done_cycle: got %0d expected 33", done_c); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_at_done: got %b expected 0", stall); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL stall_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'd42) begin failures++; $display("FAIL stall_lo: got %h expected 0000002a", lo); end
    rd_req = 1'b0;
    start  = 1'b0;
    mtlo   = 1'b0;
    mthi   = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_no_queue: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midop();
    int ndone;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL abort_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL abort_lo: got %h expected 00000000", lo); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL abort_done_pulses: got %0d expected 0", ndone); end
    mthi  = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clk);
    mthi  = 1'b0;
    wdata = 32'h0;
    checks++; if (hi !== 32'h0000_1234) begin failures++; $display("FAIL mthi_hi: got %h expected 00001234", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL mthi_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_moves();
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'hCAFE_0001;
    @(negedge clk);
    mthi  = 1'b0;
    mtlo  = 1'b0;
    checks++; if (hi !== 32'hCAFE_0001) begin failures++; $display("FAIL both_mv_hi: got %h expected cafe0001", hi); end
    checks++; if (lo !== 32'hCAFE_0001) begin failures++; $display("FAIL both_mv_lo: got %h expected cafe0001", lo); end
    // start wins over a same-cycle move; the move is dropped
    start  = 1'b1;
    op     = OP_MULTU;
    rs_val = 32'd3;
    rt_val = 32'd4;
    mtlo   = 1'b1;
    wdata  = 32'h0BAD_0BAD;
    @(negedge clk);
    start  = 1'b0;
    mtlo   = 1'b0;
    checks++; if (lo !== 32'hCAFE_0001) begin failures++; $display("FAIL start_prio_lo: got %h expected cafe0001", lo); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_prio_busy: got %b expected 1", busy); end
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    checks++; if (lo !== 32'd12) begin failures++; $display("FAIL start_prio_result: got %h expected 0000000c", lo); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    rs_val   = '0;
    rt_val   = '0;
    mthi     = 1'b0;
    mtlo     = 1'b0;
    wdata    = '0;
    rd_req   = 1'b0;
    test_reset();
    test_mult();
    test_multu_signed_pair();
    test_div();
    test_div_corners();
    test_stall_and_ignored();
    test_reset_midop();
    test_moves();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
